mem_stage_cached: RTL

Parametrised successor to the pipeline MEM stage. It serves load/store requests from a 2-way set-associative, write-through, LRU cache in front of an external wide-bus SRAM with programmable wait states. Stores use read-modify-write so neighbouring words in the SRAM line are never clobbered. `ready` low stalls the pipeline; a `flush` input invalidates the whole cache.

---
 rtl/mem_stage_cached.sv | 135 +++++++++++++
 1 files changed

// File: rtl/mem_stage_cached.sv
// mem_stage_cached: 2-way LRU write-through cache MEM stage over a wide wait-state SRAM
module mem_stage_cached #(
  parameter int DATA_W = 32,
  parameter int LINE_W = 64,
  parameter int SRAM_ADDR_W = 17,
  parameter int SETS = 64,
  parameter int SRAM_WAIT = 5,
  parameter logic [31:0] BASE_ADDR = 32'd1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_r_en,
  input  logic                   mem_w_en,
  input  logic [31:0]            addr,
  input  logic [DATA_W-1:0]      wdata,
  input  logic                   flush,
  output logic [DATA_W-1:0]      rdata,
  output logic                   ready,
  output logic                   hit,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_WE_N,
  inout  wire  [LINE_W-1:0]      SRAM_DQ
);
  localparam int OB = $clog2(LINE_W / 8);
  localparam int WB = $clog2(DATA_W / 8);
  localparam int IW = $clog2(SETS);
  localparam int TW = 32 - OB - IW;
  localparam int CW = $clog2(SRAM_WAIT + 1);
  localparam int WS = OB - WB;
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  state_t state_q;
  logic [CW-1:0] cnt_q;
  logic wr_q;
  logic [SRAM_ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] buf_q, merged, hline;
  logic [SETS-1:0] v0_q, v1_q, lru_q;
  logic [TW-1:0] tag0_q [SETS];
  logic [TW-1:0] tag1_q [SETS];
  logic [LINE_W-1:0] dat0_q [SETS];
  logic [LINE_W-1:0] dat1_q [SETS];
  logic [31:0] eff;
  logic [WS-1:0] wsel;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic req, rd_req, h0, h1, vic, unused_lsb;
  assign eff = addr - BASE_ADDR;
  assign wsel = eff[OB-1:WB];
  assign idx = eff[OB+IW-1:OB];
  assign tag = eff[31:OB+IW];
  assign unused_lsb = ^eff[WB-1:0];
  assign req = mem_r_en | mem_w_en;
  assign rd_req = mem_r_en & ~mem_w_en;
  assign h0 = v0_q[idx] && tag0_q[idx] == tag;
  assign h1 = v1_q[idx] && tag1_q[idx] == tag;
  assign hit = rst & req & (h0 | h1);
  assign hline = h0 ? dat0_q[idx] : dat1_q[idx];
  assign vic = !v0_q[idx] ? 1'b0 : !v1_q[idx] ? 1'b1 : lru_q[idx];
  assign ready = rst & ((state_q == IDLE && (!req || (rd_req && hit))) || state_q == DONE);
  assign rdata = (!ready || !rd_req) ? '0 :
                 state_q == DONE ? buf_q[wsel*DATA_W +: DATA_W] : hline[wsel*DATA_W +: DATA_W];
  assign SRAM_ADDR = addr_q;
  assign SRAM_WE_N = state_q != WR;
  assign SRAM_DQ = state_q == WR ? merged : 'z;
  // store data replaces one lane of the fetched SRAM line
  always_comb begin
    merged = buf_q;
    merged[wsel*DATA_W +: DATA_W] = wdata;
  end
  // control FSM, wait counter, line buffer and valid/LRU bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      wr_q <= 1'b0;
      addr_q <= '0;
      buf_q <= '0;
      v0_q <= '0;
      v1_q <= '0;
      lru_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req && !(rd_req && hit)) begin
            state_q <= RD;
            cnt_q <= CW'(SRAM_WAIT - 1);
            wr_q <= mem_w_en;
            addr_q <= SRAM_ADDR_W'(eff >> OB);
          end else if (rd_req && hit) begin
            lru_q[idx] <= h0;
          end else if (!req && flush) begin
            v0_q <= '0;
            v1_q <= '0;
            lru_q <= '0;
          end
        end
        RD: begin
          if (cnt_q == '0) begin
            buf_q <= SRAM_DQ;
            state_q <= wr_q ? WR : DONE;
            cnt_q <= CW'(SRAM_WAIT - 1);
          end else cnt_q <= cnt_q - 1'b1;
        end
        WR: begin
          if (cnt_q == '0) state_q <= DONE;
          else cnt_q <= cnt_q - 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          cnt_q <= '0;
          if (!wr_q) begin
            if (vic) v1_q[idx] <= 1'b1;
            else v0_q[idx] <= 1'b1;
            lru_q[idx] <= ~vic;
          end else if (h0 || h1) lru_q[idx] <= h0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  // tag and line storage: fill on read miss, update in place on write hit
  always_ff @(posedge clk) begin
    if (state_q == DONE) begin
      if (!wr_q) begin
        if (vic) begin
          tag1_q[idx] <= tag;
          dat1_q[idx] <= buf_q;
        end else begin
          tag0_q[idx] <= tag;
          dat0_q[idx] <= buf_q;
        end
      end else if (h0) dat0_q[idx] <= merged;
      else if (h1) dat1_q[idx] <= merged;
    end
  end
endmodule
